bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one single-port BRAM (1-cycle read latency) between NumReq requesters, e.g. the AXI-lite BRAM
//  controller path and display scanout/palette readers. Round-robin grant, zero-latency accept, one outstanding
//  access per requester. Each response is held in a per-requester buffer until that requester consumes it.
// PARAMETERS
//  NumReq        2   number of requesters, >= 2
//  DataWidth     64  BRAM data width, multiple of 8
//  BramAddrWidth 12  BRAM word address width
// PORTS
//  clk_i        in   1                     clock
//  rst_ni       in   1                     asynchronous active-low reset
//  req_valid_i  in   NumReq                request valid, per requester
//  req_ready_o  out  NumReq                request accepted (grant) this cycle
//  req_addr_i   in   NumReq*BramAddrWidth  word address, requester i at slice i
//  req_we_i     in   NumReq*DataWidth/8    byte write strobes; all-zero = read
//  req_wdata_i  in   NumReq*DataWidth      write data
//  rsp_valid_o  out  NumReq                response valid
//  rsp_ready_i  in   NumReq                response consumed
//  rsp_rdata_o  out  NumReq*DataWidth      read data; don't-care for write responses
//  bram_en      out  1                     BRAM enable
//  bram_we      out  DataWidth/8           BRAM byte write enables
//  bram_addr    out  BramAddrWidth         BRAM address
//  bram_wrdata  out  DataWidth             BRAM write data
//  bram_rddata  in   DataWidth             BRAM read data, valid one cycle after a read, then may change
// BEHAVIOUR
//  - Reset: rsp_valid_o=0, all rsp latches cleared, rr pointer=0. bram_en=0 and req_ready_o=0 while rst_ni low.
//  - eligible[i] = req_valid_i[i] && (!rsp_valid_o[i] || rsp_ready_i[i]).
//  - Grant (combinational, cycle T): pick first eligible index scanning ptr, ptr+1, ... mod NumReq.
//    Assert req_ready_o[g] only. No eligible requester: bram_en=0, req_ready_o=0.
//  - req_ready_o may depend on req_valid_i and rsp_ready_i. Upstream valid must not depend on ready.
//  - On grant at T: bram_en=1, bram_addr/bram_wrdata from g, bram_we=req_we_i[g]. The write occurs at T.
//  - rr pointer update at T+1: ptr <= (g+1) mod NumReq on a grant, unchanged otherwise.
//  - Response timing: rsp_valid_o[g] rises at T+1 for both reads and writes.
//  - Read response data: at T+1 rsp_rdata_o[g]=bram_rddata (bypass).
//    If not consumed at T+1, latch bram_rddata into g's buffer at T+1 and serve from the buffer until consumed.
//  - rsp_valid_o[i] falls the cycle after rsp_valid&&rsp_ready, unless i is re-granted in that same cycle.
//    On re-grant it stays 1: buffer cleared, new data bypassed next cycle.
//  - Ordering: at most one outstanding access per requester, so responses per requester are in order.
//  - Reset mid-operation: outstanding responses are dropped; the BRAM write at a grant cycle is not undone.
// CONFIGURATION
//  BRAM_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority, lowest eligible index wins; no rr pointer register.
//  - Undefined (default): round-robin as above.
// STRUCTURE
//  - Package bram_arb_pkg: rr_ptr_t typedef (logic [$clog2(NumReq)-1:0]); function next_ptr().
//  - Sub-module bram_arb_rr_picker: eligible vector + ptr in, one-hot grant + index out, purely combinational.
//    Honours BRAM_ARB_FIXED_PRIO_EN.
//  - Top level owns: BRAM muxing, per-requester rsp_valid/latched flags and data buffers, ptr register.
// TESTING
//  1. Req0 write addr 0x10 we=0xFF data 0xA5A5; then read 0x10
//     -> write on BRAM at grant cycle; read rsp_rdata_o[0]=0xA5A5 one cycle after its grant.
//  2. Req0 and req1 valid every cycle, rsp_ready=1
//     -> grants alternate 0,1,0,1; each requester gets one grant per 2 cycles.
//     With BRAM_ARB_FIXED_PRIO_EN: req0 wins every cycle.
//  3. Req1 read 0x20 (mem 0x1234), rsp_ready_i[1]=0 for 5 cycles while req0 reads 0x21
//     -> rsp_rdata_o[1] held at 0x1234 throughout; req1 not granted until consumed.
//  4. rsp_ready_i[0]=1 and req_valid_i[0]=1 in the same cycle
//     -> back-to-back grant; rsp_valid_o[0] stays 1; data switches to the new read.
//  5. Assert rst_ni low with both responses pending
//     -> rsp_valid_o=0 immediately, bram_en=0; after release first grant goes to req0.
//  6. Write strobe 0x0F over 0xFFFF...
//     -> bram_we=0x0F; readback shows only low 4 bytes changed.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
// Pointer type is sized for the largest supported requester count.
package bram_arb_pkg;

    localparam int unsigned MaxNumReq = 16;

    typedef logic [$clog2(MaxNumReq)-1:0] rr_ptr_t;

    // Round-robin successor of the granted index, wrapping at n.
    function automatic rr_ptr_t next_ptr(input rr_ptr_t g, input int unsigned n);
        if (32'(g) + 32'd1 >= n) begin
            next_ptr = '0;
        end else begin
            next_ptr = g + rr_ptr_t'(1);
        end
    endfunction

endpackage

// File: rtl/bram_arb_rr_picker.sv
// Combinational grant picker: first eligible index scanning upward from the pointer.
// BRAM_ARB_FIXED_PRIO_EN makes the scan always start at index 0.
module bram_arb_rr_picker
    import bram_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic [NumReq-1:0] eligible_i,
    input  rr_ptr_t           ptr_i,
    output logic [NumReq-1:0] gnt_oh_o,
    output rr_ptr_t           gnt_idx_o,
    output logic              gnt_any_o
);

    rr_ptr_t w_base;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    assign w_base = ptr_i;
`endif

    // Scanning offsets from high to low lets the lowest offset override.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int s = 0; s < NumReq; s++) begin
            if (w_base == rr_ptr_t'(s)) begin
                for (int k = NumReq - 1; k >= 0; k--) begin
                    if (eligible_i[(s + k) % NumReq]) begin
                        gnt_oh_o                     = '0;
                        gnt_oh_o[(s + k) % NumReq]   = 1'b1;
                        gnt_idx_o                    = rr_ptr_t'((s + k) % NumReq);
                        gnt_any_o                    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between NumReq requesters with per-requester response buffers.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int DataWidth     = 64,
    parameter int BramAddrWidth = 12
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq*BramAddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth/8-1:0]     req_we_i,
    input  logic [NumReq*DataWidth-1:0]       req_wdata_i,
    output logic [NumReq-1:0]                 rsp_valid_o,
    input  logic [NumReq-1:0]                 rsp_ready_i,
    output logic [NumReq*DataWidth-1:0]       rsp_rdata_o,
    output logic                              bram_en,
    output logic [DataWidth/8-1:0]            bram_we,
    output logic [BramAddrWidth-1:0]          bram_addr,
    output logic [DataWidth-1:0]              bram_wrdata,
    input  logic [DataWidth-1:0]              bram_rddata
);

    localparam int StrbW = DataWidth / 8;

    logic [NumReq-1:0]    r_rsp_valid;
    logic [NumReq-1:0]    r_fresh;
    logic [DataWidth-1:0] r_buf [NumReq];

    logic [NumReq-1:0]    w_eligible;
    logic [NumReq-1:0]    w_gnt_oh;
    logic                 w_gnt_any;
    rr_ptr_t              w_gnt_idx;
    rr_ptr_t              w_ptr;

    // A requester may re-issue in the same cycle its pending response is consumed.
    assign w_eligible = req_valid_i & (~r_rsp_valid | rsp_ready_i);

    bram_arb_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .eligible_i (w_eligible),
        .ptr_i      (w_ptr),
        .gnt_oh_o   (w_gnt_oh),
        .gnt_idx_o  (w_gnt_idx),
        .gnt_any_o  (w_gnt_any)
    );

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    rr_ptr_t r_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= next_ptr(w_gnt_idx, NumReq);
        end
    end

    assign w_ptr = r_ptr;
`endif

    assign req_ready_o = rst_ni ? w_gnt_oh : '0;
    assign bram_en     = rst_ni & w_gnt_any;
    assign rsp_valid_o = r_rsp_valid;

    always_comb begin
        bram_we     = '0;
        bram_addr   = '0;
        bram_wrdata = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_gnt_oh[i]) begin
                bram_we     = req_we_i[i*StrbW +: StrbW];
                bram_addr   = req_addr_i[i*BramAddrWidth +: BramAddrWidth];
                bram_wrdata = req_wdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // r_fresh marks the cycle right after a grant, when read data is bypassed
    // from the BRAM; if not consumed then, it is captured into r_buf.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= '0;
            r_fresh     <= '0;
            for (int i = 0; i < NumReq; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_gnt_oh[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_fresh[i]     <= 1'b1;
                    r_buf[i]       <= '0;
                end else if (r_rsp_valid[i] && rsp_ready_i[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                    r_fresh[i]     <= 1'b0;
                end else if (r_fresh[i]) begin
                    r_buf[i]   <= bram_rddata;
                    r_fresh[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rsp_rdata_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rsp_rdata_o[i*DataWidth +: DataWidth] = r_fresh[i] ? bram_rddata : r_buf[i];
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: reference memory plus per-requester expected-response queues.
module tb_bram_port_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int AW = 12;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*SW-1:0]   req_we_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N-1:0]      rsp_valid_o;
    logic [N-1:0]      rsp_ready_i;
    logic [N*DW-1:0]   rsp_rdata_o;
    logic              bram_en;
    logic [SW-1:0]     bram_we;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wrdata;
    logic [DW-1:0]     bram_rddata;

    always #5 clk = ~clk;

    bram_port_arbiter #(.NumReq(N), .DataWidth(DW), .BramAddrWidth(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_rddata (bram_rddata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {20'hC0DE0, a, ~{20'h0, a}};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] m;
        m = old;
        for (int b = 0; b < SW; b++) if (st[b]) m[8*b +: 8] = nw[8*b +: 8];
        return m;
    endfunction

    // BRAM model: one-cycle read latency, output garbage when not reading.
    logic [DW-1:0] bmem [4096];
    bit            bwr  [4096];
    always @(posedge clk) begin
        logic [DW-1:0] cur;
        if (bram_en) begin
            cur = bwr[bram_addr] ? bmem[bram_addr] : init_val(bram_addr);
            if (bram_we != '0) begin
                bmem[bram_addr] <= merge(cur, bram_wrdata, bram_we);
                bwr[bram_addr]  <= 1'b1;
                bram_rddata     <= {$urandom, $urandom};
            end else begin
                bram_rddata <= cur;
            end
        end else begin
            bram_rddata <= {$urandom, $urandom};
        end
    end

    // Reference model and scoreboard
    typedef struct {
        bit            rd;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          q [N][$];
    logic [DW-1:0] rmem [int];
    int            total = 0;
    int            bad   = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid_o[i]), 64'(q[i].size() != 0));
                if (rsp_valid_o[i] && q[i].size() != 0) begin
                    if (q[i][0].rd) chk($sformatf("rdata%0d", i), rsp_rdata_o[i*DW +: DW], q[i][0].d);
                    if (rsp_ready_i[i]) void'(q[i].pop_front());
                end
            end
        end
    end

    // Stimulus state
    logic [N-1:0]  v, rr, acc;
    logic [AW-1:0] ad [N];
    logic [SW-1:0] we [N];
    logic [DW-1:0] wd [N];
    int            ptr_m;
    int            gcnt [N];

    task automatic apply();
        req_valid_i = v;
        rsp_ready_i = rr;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = ad[i];
            req_we_i[i*SW +: SW]    = we[i];
            req_wdata_i[i*DW +: DW] = wd[i];
        end
    endtask

    task automatic step();
        logic [N-1:0] elig, eg;
        int g, base;
        apply();
        @(negedge clk);
        for (int i = 0; i < N; i++) elig[i] = v[i] && (q[i].size() == 0 || rr[i]);
`ifdef BRAM_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = ptr_m;
`endif
        g  = -1;
        eg = '0;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && elig[(base + k) % N]) g = (base + k) % N;
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready_o), 64'(eg));
        chk("bram_en", 64'(bram_en), 64'(g >= 0));
        if (g >= 0) begin
            chk("bram_addr", 64'(bram_addr), 64'(ad[g]));
            chk("bram_we", 64'(bram_we), 64'(we[g]));
            if (we[g] != '0) chk("bram_wrdata", bram_wrdata, wd[g]);
        end
        acc = v & req_ready_o;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                gcnt[i]++;
                if (we[i] == '0) begin
                    q[i].push_back('{rd: 1'b1, d: ref_rd(ad[i])});
                end else begin
                    rmem[int'(ad[i])] = merge(ref_rd(ad[i]), wd[i], we[i]);
                    q[i].push_back('{rd: 1'b0, d: '0});
                end
                ptr_m = (i + 1) % N;
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [SW-1:0] w,
                           input logic [DW-1:0] d);
        v[i]  = 1'b1;
        ad[i] = a;
        we[i] = w;
        wd[i] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        v = '0; rr = '1; acc = '0; ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            ad[i] = '0; we[i] = '0; wd[i] = '0; gcnt[i] = 0;
        end
        apply();
        #1;
        chk("reset rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("reset bram_en", 64'(bram_en), 64'(0));
        chk("reset req_ready", 64'(req_ready_o), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read back through requester 0
        set_req(0, 12'h010, 8'hFF, 64'hA5A5);
        step();
        v = '0; step();
        set_req(0, 12'h010, 8'h00, 64'h0);
        step();
        v = '0; step(); step();

        // Both requesters busy every cycle
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        rr = '1;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 12'($urandom_range(0, 15)), 8'h00, 64'h0);
            set_req(1, 12'($urandom_range(0, 15)), 8'h00, 64'h0);
            step();
        end
`ifdef BRAM_ARB_FIXED_PRIO_EN
        chk("grants0", 64'(gcnt[0]), 64'(8));
        chk("grants1", 64'(gcnt[1]), 64'(0));
`else
        chk("grants0", 64'(gcnt[0]), 64'(4));
        chk("grants1", 64'(gcnt[1]), 64'(4));
`endif
        v = '0; step();

        // Requester 1 holds its read response while requester 0 keeps reading
        set_req(1, 12'h020, 8'hFF, 64'h1234);
        step();
        v = '0; step();
        rr = 2'b01;
        set_req(1, 12'h020, 8'h00, 64'h0);
        set_req(0, 12'h021, 8'h00, 64'h0);
        step();
        for (int c = 0; c < 5; c++) begin
            if (acc[1]) set_req(1, 12'h020, 8'h00, 64'h0);
            set_req(0, 12'h021, 8'h00, 64'h0);
            step();
        end
        chk("req1 held grants", 64'(q[1].size()), 64'(1));
        rr = '1;
        step(); step();
        v = '0; step();

        // Back-to-back reads on requester 0 with consume in the same cycle
        set_req(0, 12'h010, 8'h00, 64'h0); step();
        set_req(0, 12'h020, 8'h00, 64'h0); step();
        set_req(0, 12'h021, 8'h00, 64'h0); step();
        v = '0; step();

        // Partial byte strobes
        set_req(0, 12'h030, 8'hFF, '1); step();
        set_req(0, 12'h030, 8'h0F, 64'h0011223344556677); step();
        set_req(0, 12'h030, 8'h00, 64'h0); step();
        v = '0; step(); step();

        // Reset with both responses pending
        rr = '0;
        set_req(0, 12'h001, 8'h00, 64'h0);
        set_req(1, 12'h002, 8'h00, 64'h0);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("midrst bram_en", 64'(bram_en), 64'(0));
        chk("midrst req_ready", 64'(req_ready_o), 64'(0));
        for (int i = 0; i < N; i++) q[i].delete();
        ptr_m = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rr = '1;
        set_req(0, 12'h003, 8'h00, 64'h0);
        set_req(1, 12'h004, 8'h00, 64'h0);
        step();
        chk("post-reset grant0", 64'(acc), 64'(2'b01));

        // Randomized traffic
        v = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !v[i]) begin
                    v[i]  = ($urandom_range(0, 99) < 60);
                    ad[i] = 12'($urandom_range(0, 15));
                    we[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                    wd[i] = {$urandom, $urandom};
                end
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        v = '0; rr = '1;
        repeat (3) step();
        for (int i = 0; i < N; i++) chk($sformatf("drain%0d", i), 64'(q[i].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
